// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//
// Execute (EX) stage of a five-stage RISC pipeline together with the EX/MEM
// pipeline register.
//
//   * Operand forwarding for both sources (RF, W-stage result, M-stage result).
//   * ALU: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA.
//   * Branch condition evaluation, branch/jump target and redirect.
//   * Optional iterative radix-2 shift-add multiplier, enabled by defining the
//     macro EXEC_MUL_EN. When the macro is undefined MulE is ignored, BusyE is
//     tied low and no multiply state exists.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   RegWriteE .. MulE          decoded E-stage controls
//   ResultSrcE, BranchOpE      result-source select, branch funct3
//   ALUControlE                ALU operation select
//   ForwardA_E, ForwardB_E     forwarding selects from the hazard unit
//   FlushE                     bubble request
//   RD1_E, RD2_E, Imm_Ext_E    register operands, extended immediate
//   PCE, PCPlus4E, ResultW     PC, PC+4, W-stage result for forwarding
//   RD_E                       destination register address
//   PCSrcE, PCTargetE          redirect request and target (combinational)
//   BusyE                      stall request while a multiply is in flight
//   RegWriteM .. ALU_ResultM   EX/MEM pipeline register contents
// -----------------------------------------------------------------------------
module execute_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             ALUSrcE,
    input  logic             BranchE,
    input  logic             JumpE,
    input  logic             MulE,
    input  logic [1:0]       ResultSrcE,
    input  logic [2:0]       BranchOpE,
    input  logic [3:0]       ALUControlE,
    input  logic [1:0]       ForwardA_E,
    input  logic [1:0]       ForwardB_E,
    input  logic             FlushE,
    input  logic [XLEN-1:0]  RD1_E,
    input  logic [XLEN-1:0]  RD2_E,
    input  logic [XLEN-1:0]  Imm_Ext_E,
    input  logic [XLEN-1:0]  PCE,
    input  logic [XLEN-1:0]  PCPlus4E,
    input  logic [XLEN-1:0]  ResultW,
    input  logic [RA_W-1:0]  RD_E,
    output logic             PCSrcE,
    output logic [XLEN-1:0]  PCTargetE,
    output logic             BusyE,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic [1:0]       ResultSrcM,
    output logic [RA_W-1:0]  RD_M,
    output logic [XLEN-1:0]  PCPlus4M,
    output logic [XLEN-1:0]  WriteDataM,
    output logic [XLEN-1:0]  ALU_ResultM
);

    localparam int SH_W = $clog2(XLEN);

    logic [XLEN-1:0] fwd_a_s;
    logic [XLEN-1:0] fwd_b_s;
    logic [XLEN-1:0] src_b_s;
    logic [SH_W-1:0] shamt_s;
    logic [XLEN-1:0] alu_res_s;
    logic            br_cond_s;
    logic [XLEN-1:0] ex_res_s;
    logic            busy_s;
    logic            mul_done_s;

    // Forwarding mux for operand A; code 11 is unused and falls back to the RF
    always_comb begin
        fwd_a_s = RD1_E;
        case (ForwardA_E)
            2'b01:   fwd_a_s = ResultW;
            2'b10:   fwd_a_s = ALU_ResultM;
            default: fwd_a_s = RD1_E;
        endcase
    end

    // Forwarding mux for operand B (also the store data)
    always_comb begin
        fwd_b_s = RD2_E;
        case (ForwardB_E)
            2'b01:   fwd_b_s = ResultW;
            2'b10:   fwd_b_s = ALU_ResultM;
            default: fwd_b_s = RD2_E;
        endcase
    end

    assign src_b_s = ALUSrcE ? Imm_Ext_E : fwd_b_s;
    assign shamt_s = src_b_s[SH_W-1:0];

    // ALU; unassigned codes produce zero
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        case (ALUControlE)
            4'b0000: alu_res_s = fwd_a_s + src_b_s;
            4'b0001: alu_res_s = fwd_a_s - src_b_s;
            4'b0010: alu_res_s = fwd_a_s & src_b_s;
            4'b0011: alu_res_s = fwd_a_s | src_b_s;
            4'b0100: alu_res_s = fwd_a_s ^ src_b_s;
            4'b0101: alu_res_s = {{(XLEN-1){1'b0}}, ($signed(fwd_a_s) < $signed(src_b_s))};
            4'b0110: alu_res_s = {{(XLEN-1){1'b0}}, (fwd_a_s < src_b_s)};
            4'b0111: alu_res_s = fwd_a_s << shamt_s;
            4'b1000: alu_res_s = fwd_a_s >> shamt_s;
            4'b1001: alu_res_s = $signed(fwd_a_s) >>> shamt_s;
            default: alu_res_s = {XLEN{1'b0}};
        endcase
    end

    // Branch condition always compares the forwarded registers, never the immediate
    always_comb begin
        br_cond_s = 1'b0;
        case (BranchOpE)
            3'b000:  br_cond_s = (fwd_a_s == fwd_b_s);
            3'b001:  br_cond_s = (fwd_a_s != fwd_b_s);
            3'b100:  br_cond_s = ($signed(fwd_a_s) < $signed(fwd_b_s));
            3'b101:  br_cond_s = !($signed(fwd_a_s) < $signed(fwd_b_s));
            3'b110:  br_cond_s = (fwd_a_s < fwd_b_s);
            3'b111:  br_cond_s = !(fwd_a_s < fwd_b_s);
            default: br_cond_s = 1'b0;
        endcase
    end

    assign PCTargetE = PCE + Imm_Ext_E;
    assign PCSrcE    = FlushE ? 1'b0 : ((BranchE & br_cond_s) | JumpE);

`ifdef EXEC_MUL_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } mul_state_t;

    mul_state_t      state_q, state_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [SH_W-1:0] cnt_q, cnt_d;

    // Multiply sequencer: flush wins over everything and returns to IDLE
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        busy_s     = 1'b0;
        mul_done_s = 1'b0;
        if (FlushE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (MulE) begin
                        busy_s   = 1'b1;
                        mcand_d  = fwd_a_s;
                        mplier_d = src_b_s;
                        acc_d    = {XLEN{1'b0}};
                        cnt_d    = {SH_W{1'b0}};
                        state_d  = ST_MUL;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
                ST_MUL: begin
                    // Only the low XLEN product bits are kept, so shifting the
                    // multiplicand left truncates naturally.
                    busy_s   = 1'b1;
                    acc_d    = acc_q + (mplier_q[0] ? mcand_q : {XLEN{1'b0}});
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + SH_W'(1'b1);
                    if (cnt_q == SH_W'(XLEN - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_MUL;
                    end
                end
                ST_DONE: begin
                    // Leave unconditionally so the still-held MulE does not retrigger
                    mul_done_s = 1'b1;
                    state_d    = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Multiply sequencer state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= {XLEN{1'b0}};
            mplier_q <= {XLEN{1'b0}};
            acc_q    <= {XLEN{1'b0}};
            cnt_q    <= {SH_W{1'b0}};
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ex_res_s = mul_done_s ? acc_q : alu_res_s;
    // Stall is suppressed while reset is held, even if MulE is asserted
    assign BusyE    = busy_s & ~rst;
`else
    logic unused_mul_s;

    assign unused_mul_s = MulE;
    assign busy_s       = 1'b0;
    assign mul_done_s   = 1'b0;
    assign ex_res_s     = alu_res_s;
    assign BusyE        = 1'b0;
`endif

    // EX/MEM pipeline register; a bubble clears only the control fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 2'b00;
            RD_M        <= {RA_W{1'b0}};
            PCPlus4M    <= {XLEN{1'b0}};
            WriteDataM  <= {XLEN{1'b0}};
            ALU_ResultM <= {XLEN{1'b0}};
        end else if (FlushE || busy_s) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 2'b00;
            RD_M        <= {RA_W{1'b0}};
        end else begin
            RegWriteM   <= RegWriteE;
            MemWriteM   <= MemWriteE;
            ResultSrcM  <= ResultSrcE;
            RD_M        <= RD_E;
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= fwd_b_s;
            ALU_ResultM <= ex_res_s;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, MulE, FlushE;
    logic [1:0]  ResultSrcE, ForwardA_E, ForwardB_E;
    logic [2:0]  BranchOpE;
    logic [3:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic        PCSrcE, BusyE, RegWriteM, MemWriteM;
    logic [31:0] PCTargetE, PCPlus4M, WriteDataM, ALU_ResultM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;

    int checks;
    int failures;

    execute_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
        .BranchE(BranchE), .JumpE(JumpE), .MulE(MulE),
        .ResultSrcE(ResultSrcE), .BranchOpE(BranchOpE), .ALUControlE(ALUControlE),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .FlushE(FlushE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .ResultW(ResultW), .RD_E(RD_E),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BusyE(BusyE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALU_ResultM(ALU_ResultM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_nop();
        RegWriteE = 1'b0; MemWriteE = 1'b0; ALUSrcE = 1'b0; BranchE = 1'b0;
        JumpE = 1'b0; MulE = 1'b0; FlushE = 1'b0; ResultSrcE = 2'b00;
        ForwardA_E = 2'b00; ForwardB_E = 2'b00; BranchOpE = 3'b000;
        ALUControlE = 4'b0000; RD1_E = 32'h0; RD2_E = 32'h0; Imm_Ext_E = 32'h0;
        PCE = 32'h0; PCPlus4E = 32'h0; ResultW = 32'h0; RD_E = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_nop();
        RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 2'b11; RD_E = 5'd3;
        RD1_E = 32'h11; Imm_Ext_E = 32'h4; ALUSrcE = 1'b1; PCPlus4E = 32'h14;
        PCE = 32'h10; MulE = 1'b1;
        #3;
        checks++; if (PCTargetE !== 32'h14) begin failures++; $display("FAIL rst_pctarget got=%h exp=%h", PCTargetE, 32'h14); end
        checks++; if (BusyE !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", BusyE); end
        step();
        checks++; if (RegWriteM !== 1'b0) begin failures++; $display("FAIL rst_regwrite got=%b exp=0", RegWriteM); end
        checks++; if (MemWriteM !== 1'b0) begin failures++; $display("FAIL rst_memwrite got=%b exp=0", MemWriteM); end
        checks++; if (ALU_ResultM !== 32'h0) begin failures++; $display("FAIL rst_alu got=%h exp=0", ALU_ResultM); end
        checks++; if ({ResultSrcM, RD_M} !== 7'h0) begin failures++; $display("FAIL rst_ctrl got=%h exp=0", {ResultSrcM, RD_M}); end
        checks++; if ({PCPlus4M, WriteDataM} !== 64'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", {PCPlus4M, WriteDataM}); end
        set_nop();
        rst = 1'b0;
        step();
    endtask

    task automatic test_add_overflow();
        set_nop();
        RD1_E = 32'h7FFFFFFF; Imm_Ext_E = 32'h1; ALUSrcE = 1'b1; RegWriteE = 1'b1;
        RD2_E = 32'h0000AAAA; RD_E = 5'd5; ResultSrcE = 2'b01; PCPlus4E = 32'h104;
        step();
        checks++; if (ALU_ResultM !== 32'h80000000) begin failures++; $display("FAIL add_ovf got=%h exp=%h", ALU_ResultM, 32'h80000000); end
        checks++; if (RegWriteM !== 1'b1) begin failures++; $display("FAIL add_regwrite got=%b exp=1", RegWriteM); end
        checks++; if (RD_M !== 5'd5) begin failures++; $display("FAIL add_rd got=%0d exp=5", RD_M); end
        checks++; if (ResultSrcM !== 2'b01) begin failures++; $display("FAIL add_ressrc got=%b exp=01", ResultSrcM); end
        checks++; if (PCPlus4M !== 32'h104) begin failures++; $display("FAIL add_pc4 got=%h exp=104", PCPlus4M); end
        checks++; if (WriteDataM !== 32'h0000AAAA) begin failures++; $display("FAIL add_wdata got=%h exp=aaaa", WriteDataM); end
        RegWriteE = 1'b0;
        step();
        checks++; if (RegWriteM !== 1'b0) begin failures++; $display("FAIL add_regwrite_follow got=%b exp=0", RegWriteM); end
    endtask

    task automatic test_forwarding();
        set_nop();
        RD1_E = 32'd2; Imm_Ext_E = 32'd3; ALUSrcE = 1'b1;
        step();
        checks++; if (ALU_ResultM !== 32'd5) begin failures++; $display("FAIL fwd_setup got=%0d exp=5", ALU_ResultM); end
        set_nop();
        ForwardA_E = 2'b10; RD1_E = 32'd9; RD2_E = 32'd2; ALUControlE = 4'b0001;
        step();
        checks++; if (ALU_ResultM !== 32'd3) begin failures++; $display("FAIL fwd_a10 got=%0d exp=3", ALU_ResultM); end
        ForwardA_E = 2'b11;
        step();
        checks++; if (ALU_ResultM !== 32'd7) begin failures++; $display("FAIL fwd_a11 got=%0d exp=7", ALU_ResultM); end
        ForwardA_E = 2'b01; ResultW = 32'd100;
        step();
        checks++; if (ALU_ResultM !== 32'd98) begin failures++; $display("FAIL fwd_a01 got=%0d exp=98", ALU_ResultM); end
        ForwardA_E = 2'b00; ForwardB_E = 2'b01; RD1_E = 32'h50; ResultW = 32'h30;
        step();
        checks++; if (ALU_ResultM !== 32'h20) begin failures++; $display("FAIL fwd_b01 got=%h exp=20", ALU_ResultM); end
        checks++; if (WriteDataM !== 32'h30) begin failures++; $display("FAIL fwd_b01_wdata got=%h exp=30", WriteDataM); end
        ForwardB_E = 2'b10; ALUSrcE = 1'b1; Imm_Ext_E = 32'h1; RD2_E = 32'h5;
        step();
        checks++; if (ALU_ResultM !== 32'h4F) begin failures++; $display("FAIL fwd_imm got=%h exp=4f", ALU_ResultM); end
        checks++; if (WriteDataM !== 32'h20) begin failures++; $display("FAIL fwd_b10_wdata got=%h exp=20", WriteDataM); end
    endtask

    task automatic test_alu_ops();
        logic [3:0]  ops [9];
        logic [31:0] exps [9];
        ops  = '{4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1111};
        exps = '{32'h00000000, 32'h80000034, 32'h80000034, 32'h00000001, 32'h00000000,
                 32'h00000100, 32'h08000001, 32'hF8000001, 32'h00000000};
        set_nop();
        RD1_E = 32'h80000010; RD2_E = 32'h00000024;
        for (int i = 0; i < 9; i++) begin
            ALUControlE = ops[i];
            step();
            checks++; if (ALU_ResultM !== exps[i]) begin failures++; $display("FAIL alu_op%b got=%h exp=%h", ops[i], ALU_ResultM, exps[i]); end
        end
    endtask

    task automatic test_branch();
        set_nop();
        BranchE = 1'b1; BranchOpE = 3'b100; RD1_E = 32'hFFFFFFFF; RD2_E = 32'h1;
        ALUSrcE = 1'b1; Imm_Ext_E = 32'h20; PCE = 32'h100;
        #1;
        checks++; if (PCSrcE !== 1'b1) begin failures++; $display("FAIL br_lt got=%b exp=1", PCSrcE); end
        checks++; if (PCTargetE !== 32'h120) begin failures++; $display("FAIL br_target got=%h exp=120", PCTargetE); end
        BranchOpE = 3'b110; #1;
        checks++; if (PCSrcE !== 1'b0) begin failures++; $display("FAIL br_ltu got=%b exp=0", PCSrcE); end
        BranchOpE = 3'b111; #1;
        checks++; if (PCSrcE !== 1'b1) begin failures++; $display("FAIL br_geu got=%b exp=1", PCSrcE); end
        BranchOpE = 3'b101; #1;
        checks++; if (PCSrcE !== 1'b0) begin failures++; $display("FAIL br_ge got=%b exp=0", PCSrcE); end
        RD2_E = 32'hFFFFFFFF; BranchOpE = 3'b000; #1;
        checks++; if (PCSrcE !== 1'b1) begin failures++; $display("FAIL br_eq got=%b exp=1", PCSrcE); end
        BranchOpE = 3'b001; #1;
        checks++; if (PCSrcE !== 1'b0) begin failures++; $display("FAIL br_ne got=%b exp=0", PCSrcE); end
        BranchOpE = 3'b010; #1;
        checks++; if (PCSrcE !== 1'b0) begin failures++; $display("FAIL br_010 got=%b exp=0", PCSrcE); end
        BranchOpE = 3'b000; BranchE = 1'b0; #1;
        checks++; if (PCSrcE !== 1'b0) begin failures++; $display("FAIL br_disabled got=%b exp=0", PCSrcE); end
        JumpE = 1'b1; #1;
        checks++; if (PCSrcE !== 1'b1) begin failures++; $display("FAIL jump got=%b exp=1", PCSrcE); end
        FlushE = 1'b1; #1;
        checks++; if (PCSrcE !== 1'b0) begin failures++; $display("FAIL jump_flush got=%b exp=0", PCSrcE); end
        set_nop();
        step();
    endtask

    task automatic test_flush();
        set_nop();
        RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 2'b10; RD_E = 5'd7;
        RD1_E = 32'h5; Imm_Ext_E = 32'h5; ALUSrcE = 1'b1;
        step();
        checks++; if ({RegWriteM, MemWriteM, ResultSrcM, RD_M} !== {1'b1, 1'b1, 2'b10, 5'd7}) begin failures++; $display("FAIL flush_pre got=%h exp=%h", {RegWriteM, MemWriteM, ResultSrcM, RD_M}, {1'b1, 1'b1, 2'b10, 5'd7}); end
        FlushE = 1'b1;
        #1;
        checks++; if (BusyE !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", BusyE); end
        step();
        checks++; if ({RegWriteM, MemWriteM, ResultSrcM, RD_M} !== 9'h0) begin failures++; $display("FAIL flush_bubble got=%h exp=0", {RegWriteM, MemWriteM, ResultSrcM, RD_M}); end
        set_nop();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [3];
        logic [31:0] b [3];
        a = '{32'h1, 32'hFFFFFFFF, 32'h12345678};
        b = '{32'h2, 32'h1, 32'h11111111};
        set_nop();
        for (int i = 0; i < 3; i++) begin
            RD1_E = a[i]; RD2_E = b[i]; RD_E = 5'(i + 1); RegWriteE = 1'b1;
            step();
            checks++; if (ALU_ResultM !== a[i] + b[i]) begin failures++; $display("FAIL b2b_%0d got=%h exp=%h", i, ALU_ResultM, a[i] + b[i]); end
            checks++; if (RD_M !== 5'(i + 1)) begin failures++; $display("FAIL b2b_rd_%0d got=%0d exp=%0d", i, RD_M, i + 1); end
        end
        set_nop();
        step();
    endtask

`ifdef EXEC_MUL_EN
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input string name);
        int n;
        set_nop();
        RD1_E = a; RD2_E = b; MulE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd9;
        #1;
        n = 0;
        while (BusyE === 1'b1 && n < 100) begin
            n++;
            step();
            checks++; if (RegWriteM !== 1'b0) begin failures++; $display("FAIL %s_bubble got=%b exp=0", name, RegWriteM); end
        end
        checks++; if (n !== 33) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=33", name, n); end
        step();
        set_nop();
        checks++; if (ALU_ResultM !== exp) begin failures++; $display("FAIL %s_product got=%h exp=%h", name, ALU_ResultM, exp); end
        checks++; if ({RegWriteM, RD_M} !== {1'b1, 5'd9}) begin failures++; $display("FAIL %s_ctrl got=%h exp=%h", name, {RegWriteM, RD_M}, {1'b1, 5'd9}); end
        #1;
        checks++; if (BusyE !== 1'b0) begin failures++; $display("FAIL %s_no_restart got=%b exp=0", name, BusyE); end
    endtask

    task automatic test_mul();
        run_mul(32'd7, 32'd6, 32'd42, "mul_7x6");
        run_mul(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, "mul_ovf");
        run_mul(32'd0, 32'd12345, 32'd0, "mul_zero");
    endtask

    task automatic test_mul_flush();
        set_nop();
        RD1_E = 32'd7; RD2_E = 32'd6; MulE = 1'b1; RegWriteE = 1'b1; MemWriteE = 1'b1;
        for (int i = 0; i < 11; i++) step();
        checks++; if (BusyE !== 1'b1) begin failures++; $display("FAIL mflush_pre got=%b exp=1", BusyE); end
        FlushE = 1'b1;
        #1;
        checks++; if (BusyE !== 1'b0) begin failures++; $display("FAIL mflush_busy got=%b exp=0", BusyE); end
        step();
        checks++; if ({RegWriteM, MemWriteM} !== 2'b00) begin failures++; $display("FAIL mflush_bubble got=%b exp=00", {RegWriteM, MemWriteM}); end
        set_nop();
        #1;
        checks++; if (BusyE !== 1'b0) begin failures++; $display("FAIL mflush_idle got=%b exp=0", BusyE); end
        run_mul(32'd3, 32'd3, 32'd9, "mflush_fresh");
    endtask

    task automatic test_mul_reset();
        set_nop();
        RD1_E = 32'd7; RD2_E = 32'd6; MulE = 1'b1; RegWriteE = 1'b1;
        for (int i = 0; i < 5; i++) step();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (BusyE !== 1'b0) begin failures++; $display("FAIL mrst_busy got=%b exp=0", BusyE); end
        checks++; if ({RegWriteM, MemWriteM, ResultSrcM, RD_M} !== 9'h0) begin failures++; $display("FAIL mrst_ctrl got=%h exp=0", {RegWriteM, MemWriteM, ResultSrcM, RD_M}); end
        checks++; if ({ALU_ResultM, PCPlus4M, WriteDataM} !== 96'h0) begin failures++; $display("FAIL mrst_data got=%h exp=0", {ALU_ResultM, PCPlus4M, WriteDataM}); end
        step();
        set_nop();
        rst = 1'b0;
        step();
        checks++; if (ALU_ResultM !== 32'h0) begin failures++; $display("FAIL mrst_no_partial got=%h exp=0", ALU_ResultM); end
        run_mul(32'd3, 32'd3, 32'd9, "mrst_fresh");
    endtask
`else
    task automatic test_mul_ignored();
        set_nop();
        RD1_E = 32'd3; RD2_E = 32'd4; MulE = 1'b1; RegWriteE = 1'b1;
        #1;
        checks++; if (BusyE !== 1'b0) begin failures++; $display("FAIL nomul_busy got=%b exp=0", BusyE); end
        step();
        checks++; if (ALU_ResultM !== 32'd7) begin failures++; $display("FAIL nomul_add got=%0d exp=7", ALU_ResultM); end
        checks++; if (RegWriteM !== 1'b1) begin failures++; $display("FAIL nomul_regwrite got=%b exp=1", RegWriteM); end
        set_nop();
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_add_overflow();
        test_forwarding();
        test_alu_ops();
        test_branch();
        test_flush();
        test_back_to_back();
`ifdef EXEC_MUL_EN
        test_mul();
        test_mul_flush();
        test_mul_reset();
`else
        test_mul_ignored();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
